// File: rtl/pipe_fetch_unit.sv
// ============================================================================
// Module  : pipe_fetch_unit
// Purpose : Instruction-fetch stage driving the IF/ID register, with a
//           one-entry hold buffer for stalls and EX-stage redirects.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       newInst,
    output logic [31:0]       pc4,
    output logic              wir,
    output logic [31:0]       fetch_pc,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      hbuf_q, hbuf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             w_in_req;
    logic             w_in_hold;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_target;
    logic             unused_ok;

    assign w_in_req   = (state_q == c_st_req);
    assign w_in_hold  = (state_q == c_st_hold);
    assign w_pc_plus4 = pc_q + 32'd4;
    assign w_target   = {redirect_pc[31:2], 2'b00};
    assign unused_ok  = &{1'b0, redirect_pc[1:0]};

    // Outputs are purely combinational so a ready memory hands its word to
    // IF/ID in the same cycle the address is issued.
    always_comb begin
        imem_req    = w_in_req;
        imem_addr   = pc_q;
        fetch_pc    = pc_q;
        pc4         = w_pc_plus4;
        fetch_count = count_q;
        wir         = ((w_in_req & imem_ready) | w_in_hold) & ~stall & ~redirect;
        if (w_in_req && imem_ready) begin
            newInst = imem_rdata;
        end else if (w_in_hold) begin
            newInst = hbuf_q;
        end else begin
            newInst = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hbuf_d  = hbuf_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, wir};
        case (state_q)
            c_st_idle: begin
                state_d = c_st_req;
            end
            c_st_req: begin
                if (redirect) begin
                    pc_d    = w_target;
                    state_d = c_st_req;
                end else if (imem_ready && !stall) begin
                    pc_d    = w_pc_plus4;
                end else if (imem_ready) begin
                    hbuf_d  = imem_rdata;
                    state_d = c_st_hold;
                end
            end
            c_st_hold: begin
                if (redirect) begin
                    pc_d    = w_target;
                    state_d = c_st_req;
                end else if (!stall) begin
                    pc_d    = w_pc_plus4;
                    state_d = c_st_req;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= c_st_idle;
            pc_q    <= RESET_PC;
            hbuf_q  <= 32'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hbuf_q  <= hbuf_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch_unit.sv
// ============================================================================
// Module  : tb_pipe_fetch_unit
// Purpose : Directed, table-driven self-checking bench for pipe_fetch_unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_fetch_unit;

    logic        clk;
    logic        clrn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] newInst;
    logic [31:0] pc4;
    logic        wir;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;

    logic        clrn4;
    logic        imem_req4;
    logic [31:0] imem_addr4;
    logic [31:0] imem_rdata4;
    logic [31:0] newInst4;
    logic [31:0] pc4_4;
    logic        wir4;
    logic [31:0] fetch_pc4;
    logic [3:0]  fetch_count4;

    int n_total;
    int n_pass;

    // Memory model: each word is its own address tagged with A in the top nibble.
    assign imem_rdata  = imem_addr  | 32'hA000_0000;
    assign imem_rdata4 = imem_addr4 | 32'hA000_0000;

    pipe_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .clrn(clrn), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .newInst(newInst),
        .pc4(pc4), .wir(wir), .fetch_pc(fetch_pc), .fetch_count(fetch_count)
    );

    pipe_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut4 (
        .clk(clk), .clrn(clrn4), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'd0), .imem_req(imem_req4), .imem_addr(imem_addr4),
        .imem_ready(1'b1), .imem_rdata(imem_rdata4), .newInst(newInst4),
        .pc4(pc4_4), .wir(wir4), .fetch_pc(fetch_pc4), .fetch_count(fetch_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic        ready;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        wir;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic r, logic rd, logic [31:0] rpc,
                                logic q, logic [31:0] a, logic w,
                                logic [31:0] i, logic [31:0] p, logic [31:0] c);
        vec_t v;
        v.stall = s; v.redirect = r; v.ready = rd; v.rpc = rpc;
        v.req = q; v.addr = a; v.wir = w; v.inst = i; v.pc4 = p; v.cnt = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        clrn = 1'b0; clrn4 = 1'b0;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_1234; imem_ready = 1'b1;

        //       stall redir ready rpc           req addr          wir inst          pc4           cnt
        vecs.push_back(mk(0,0,1,32'h0,          0,32'h0,         0,32'h0,         32'h4,        32'd0)); // IDLE
        vecs.push_back(mk(0,0,1,32'h0,          1,32'h0,         1,32'hA000_0000, 32'h4,        32'd0));
        vecs.push_back(mk(0,0,1,32'h0,          1,32'h4,         1,32'hA000_0004, 32'h8,        32'd1));
        vecs.push_back(mk(1,0,1,32'h0,          1,32'h8,         0,32'hA000_0008, 32'hC,        32'd2)); // into HOLD
        vecs.push_back(mk(1,0,1,32'h0,          0,32'h8,         0,32'hA000_0008, 32'hC,        32'd2));
        vecs.push_back(mk(1,0,1,32'h0,          0,32'h8,         0,32'hA000_0008, 32'hC,        32'd2));
        vecs.push_back(mk(0,0,1,32'h0,          0,32'h8,         1,32'hA000_0008, 32'hC,        32'd2)); // release
        vecs.push_back(mk(0,0,1,32'h0,          1,32'hC,         1,32'hA000_000C, 32'h10,       32'd3));
        vecs.push_back(mk(0,0,0,32'h0,          1,32'h10,        0,32'h0,         32'h14,       32'd4)); // wait
        vecs.push_back(mk(0,0,0,32'h0,          1,32'h10,        0,32'h0,         32'h14,       32'd4));
        vecs.push_back(mk(0,0,1,32'h0,          1,32'h10,        1,32'hA000_0010, 32'h14,       32'd4));
        vecs.push_back(mk(1,0,1,32'h0,          1,32'h14,        0,32'hA000_0014, 32'h18,       32'd5));
        vecs.push_back(mk(0,1,1,32'h203,        0,32'h14,        0,32'hA000_0014, 32'h18,       32'd5)); // redirect in HOLD
        vecs.push_back(mk(0,0,1,32'h0,          1,32'h200,       1,32'hA000_0200, 32'h204,      32'd5));
        vecs.push_back(mk(1,1,1,32'h300,        1,32'h204,       0,32'hA000_0204, 32'h208,      32'd6)); // redirect+stall+ready
        vecs.push_back(mk(0,0,0,32'h0,          1,32'h300,       0,32'h0,         32'h304,      32'd6));
        vecs.push_back(mk(0,1,0,32'hFFFF_FFFF,  1,32'h300,       0,32'h0,         32'h304,      32'd6));
        vecs.push_back(mk(0,0,1,32'h0,          1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 32'h0,        32'd6)); // pc wrap
        vecs.push_back(mk(1,0,1,32'h0,          1,32'h0,         0,32'hA000_0000, 32'h4,        32'd7));
        vecs.push_back(mk(1,0,1,32'h0,          0,32'h0,         0,32'hA000_0000, 32'h4,        32'd7));

        // Reset state while clrn is held low
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_wir",   {31'd0, wir},      32'd0);
        chk("rst_inst",  newInst,           32'd0);
        chk("rst_pc4",   pc4,               32'h4);
        chk("rst_pc",    fetch_pc,          32'h0);
        chk("rst_cnt",   fetch_count,       32'd0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            clrn        = 1'b1;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            imem_ready  = vecs[i].ready;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
            chk($sformatf("v%0d_req", i),  {31'd0, imem_req}, {31'd0, vecs[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr,         vecs[i].addr);
            chk($sformatf("v%0d_wir", i),  {31'd0, wir},      {31'd0, vecs[i].wir});
            chk($sformatf("v%0d_inst", i), newInst,           vecs[i].inst);
            chk($sformatf("v%0d_pc4", i),  pc4,               vecs[i].pc4);
            chk($sformatf("v%0d_cnt", i),  fetch_count,       vecs[i].cnt);
        end

        // Asynchronous reset mid-HOLD, checked before the next rising edge
        #1 clrn = 1'b0;
        stall = 1'b0;
        #1;
        chk("arst_req",  {31'd0, imem_req}, 32'd0);
        chk("arst_wir",  {31'd0, wir},      32'd0);
        chk("arst_inst", newInst,           32'd0);
        chk("arst_pc4",  pc4,               32'h4);
        chk("arst_pc",   fetch_pc,          32'h0);
        chk("arst_cnt",  fetch_count,       32'd0);

        // 4-bit counter wrap on the narrow build: 15 pulses, then one more wraps to 0
        @(posedge clk); #1;
        clrn4 = 1'b1;
        @(negedge clk);
        chk("c4_idle_wir", {31'd0, wir4},         32'd0);
        chk("c4_idle_cnt", {28'd0, fetch_count4}, 32'd0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        chk("c4_cnt15",    {28'd0, fetch_count4}, 32'd15);
        chk("c4_wir",      {31'd0, wir4},         32'd1);
        @(negedge clk);
        chk("c4_wrap",     {28'd0, fetch_count4}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
